// File: rtl/clint_responder_pkg.sv
// Shared definitions for the core-local interruptor: register offsets,
// response FSM encodings and the register decoder.
package clint_responder_pkg;

  localparam logic [15:0] CLINT_MSIP        = 16'h0000;
  localparam logic [15:0] CLINT_MTIMECMP_LO = 16'h4000;
  localparam logic [15:0] CLINT_MTIMECMP_HI = 16'h4004;
  localparam logic [15:0] CLINT_MTIME_LO    = 16'hBFF8;
  localparam logic [15:0] CLINT_MTIME_HI    = 16'hBFFC;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RESP = 1'b1;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_MSIP,
    REG_CMP_LO,
    REG_CMP_HI,
    REG_TIME_LO,
    REG_TIME_HI
  } reg_sel_t;

  // Byte lanes within a word are not decoded, so only the word index is taken.
  function automatic reg_sel_t decode_reg(input logic [13:0] word_idx);
    reg_sel_t r;
    case ({word_idx, 2'b00})
      CLINT_MSIP:        r = REG_MSIP;
      CLINT_MTIMECMP_LO: r = REG_CMP_LO;
      CLINT_MTIMECMP_HI: r = REG_CMP_HI;
      CLINT_MTIME_LO:    r = REG_TIME_LO;
      CLINT_MTIME_HI:    r = REG_TIME_HI;
      default:           r = REG_NONE;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/byte_merge32.sv
// Combinational write-strobe merge of a new 32-bit word into an old one.
module byte_merge32 (
  input  logic [31:0] old_word,
  input  logic [31:0] new_word,
  input  logic [3:0]  wstrb,
  output logic [31:0] merged
);

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign merged[8*gi +: 8] = wstrb[gi] ? new_word[8*gi +: 8] : old_word[8*gi +: 8];
  end

endmodule

// File: rtl/clint_responder.sv
// Core-local interruptor: msip, mtime, mtimecmp behind a valid/ready bus.
// Optional CLINT_MTIME_SNAPSHOT_EN latches mtime_hi on an mtime_lo read.
module clint_responder
  import clint_responder_pkg::*;
#(
  parameter int unsigned TICK_DIV       = 1,
  parameter logic [63:0] MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sel,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [15:0] mem_addr,
  input  logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        IRQ3,
  output logic        IRQ7
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [0:0]    state_reg;
  logic [31:0]   rdata_reg;
  logic          msip_reg, msip_next;
  logic [63:0]   mtime_reg, mtime_next;
  logic [63:0]   mtimecmp_reg, mtimecmp_next;
  logic [PW-1:0] presc_reg, presc_next;
  logic          irq3_reg, irq7_reg;

  logic          accept, is_write, wr_en, tick;
  reg_sel_t      target;
  logic [31:0]   live_word, read_word, merged_word;
  logic [63:0]   mtime_ticked;

  logic unused_addr_lsb;
  assign unused_addr_lsb = &{1'b0, mem_addr[1:0]};

  assign accept   = (state_reg == ST_IDLE) && sel && mem_valid;
  assign is_write = |mem_wstrb;
  assign wr_en    = accept && is_write;
  assign target   = decode_reg(mem_addr[15:2]);

  always_comb begin
    live_word = 32'h0;
    case (target)
      REG_MSIP:    live_word = {31'h0, msip_reg};
      REG_CMP_LO:  live_word = mtimecmp_reg[31:0];
      REG_CMP_HI:  live_word = mtimecmp_reg[63:32];
      REG_TIME_LO: live_word = mtime_reg[31:0];
      REG_TIME_HI: live_word = mtime_reg[63:32];
      default:     live_word = 32'h0;
    endcase
  end

`ifdef CLINT_MTIME_SNAPSHOT_EN
  logic [31:0] shadow_reg;

  assign read_word = (target == REG_TIME_HI) ? shadow_reg : live_word;

  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_reg <= 32'h0;
    end else if (accept && target == REG_TIME_LO && !is_write) begin
      shadow_reg <= mtime_reg[63:32];
    end else if (wr_en && target == REG_TIME_HI) begin
      shadow_reg <= merged_word;
    end
  end
`else
  assign read_word = live_word;
`endif

  byte_merge32 u_merge (
    .old_word (live_word),
    .new_word (mem_wdata),
    .wstrb    (mem_wstrb),
    .merged   (merged_word)
  );

  assign tick         = (presc_reg == PW'(TICK_DIV - 1));
  assign presc_next   = tick ? '0 : presc_reg + 1'b1;
  assign mtime_ticked = mtime_reg + {63'h0, tick};

  // A written mtime half overrides the tick; the other half keeps its ticked value.
  always_comb begin
    msip_next     = msip_reg;
    mtime_next    = mtime_ticked;
    mtimecmp_next = mtimecmp_reg;
    if (wr_en) begin
      case (target)
        REG_MSIP:    msip_next                 = merged_word[0];
        REG_CMP_LO:  mtimecmp_next[31:0]       = merged_word;
        REG_CMP_HI:  mtimecmp_next[63:32]      = merged_word;
        REG_TIME_LO: mtime_next[31:0]          = merged_word;
        REG_TIME_HI: mtime_next[63:32]         = merged_word;
        default:     ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      rdata_reg    <= 32'h0;
      msip_reg     <= 1'b0;
      mtime_reg    <= 64'h0;
      mtimecmp_reg <= MTIMECMP_RESET;
      presc_reg    <= '0;
      irq3_reg     <= 1'b0;
      irq7_reg     <= 1'b0;
    end else begin
      state_reg    <= accept ? ST_RESP : ST_IDLE;
      rdata_reg    <= accept ? read_word : 32'h0;
      msip_reg     <= msip_next;
      mtime_reg    <= mtime_next;
      mtimecmp_reg <= mtimecmp_next;
      presc_reg    <= presc_next;
      irq3_reg     <= msip_next;
      irq7_reg     <= (mtime_next >= mtimecmp_next);
    end
  end

  assign mem_ready = (state_reg == ST_RESP);
  assign mem_rdata = rdata_reg;
  assign IRQ3      = irq3_reg;
  assign IRQ7      = irq7_reg;

endmodule

// File: tb/tb_clint_responder.sv
// Randomized self-checking bench for clint_responder against a
// cycle-count based reference model of the register map and timer.
module tb_clint_responder;

  localparam int unsigned TICK_DIV = 4;
  localparam logic [63:0] CMP_RST  = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        reset;
  logic        sel;
  logic        mem_valid;
  logic        mem_ready;
  logic [15:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        IRQ3;
  logic        IRQ7;

  clint_responder #(
    .TICK_DIV       (TICK_DIV),
    .MTIMECMP_RESET (CMP_RST)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .sel       (sel),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_wstrb (mem_wstrb),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .IRQ3      (IRQ3),
    .IRQ7      (IRQ7)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [63:0] m_time;
  logic [63:0] m_cmp;
  logic        m_msip;
  logic [31:0] m_shadow;
  logic [31:0] m_rd;
  logic        m_busy;
  logic        m_rdv;
  int unsigned m_cyc;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] strb);
    logic [31:0] mask;
    mask = 32'h0;
    for (int i = 0; i < 4; i++) if (strb[i]) mask = mask | (32'hFF << (8 * i));
    return (old_w & ~mask) | (new_w & mask);
  endfunction

  // Advance the model by one clock edge, using the inputs the bench drove.
  task automatic model_edge();
    logic [63:0] t;
    logic [31:0] tmp;
    logic [15:0] w;
    logic        acc;
    if (reset) begin
      m_time = 64'h0; m_cmp = CMP_RST; m_msip = 1'b0; m_shadow = 32'h0;
      m_rd = 32'h0; m_busy = 1'b0; m_rdv = 1'b0; m_cyc = 0;
    end else begin
      t = m_time + ((m_cyc % TICK_DIV) == TICK_DIV - 1 ? 64'd1 : 64'd0);
      m_cyc++;
      acc    = !m_busy && sel && mem_valid;
      m_busy = acc;
      m_rdv  = acc && (mem_wstrb == 4'h0);
      m_rd   = 32'h0;
      if (acc) begin
        w = {mem_addr[15:2], 2'b00};
        case (w)
          16'h0000: m_rd = {31'h0, m_msip};
          16'h4000: m_rd = m_cmp[31:0];
          16'h4004: m_rd = m_cmp[63:32];
          16'hBFF8: m_rd = m_time[31:0];
`ifdef CLINT_MTIME_SNAPSHOT_EN
          16'hBFFC: m_rd = m_shadow;
`else
          16'hBFFC: m_rd = m_time[63:32];
`endif
          default:  m_rd = 32'h0;
        endcase
        if (mem_wstrb != 4'h0) begin
          case (w)
            16'h0000: begin tmp = merge({31'h0, m_msip}, mem_wdata, mem_wstrb); m_msip = tmp[0]; end
            16'h4000: m_cmp[31:0]  = merge(m_cmp[31:0], mem_wdata, mem_wstrb);
            16'h4004: m_cmp[63:32] = merge(m_cmp[63:32], mem_wdata, mem_wstrb);
            16'hBFF8: t[31:0]      = merge(m_time[31:0], mem_wdata, mem_wstrb);
            16'hBFFC: begin t[63:32] = merge(m_time[63:32], mem_wdata, mem_wstrb); m_shadow = t[63:32]; end
            default: ;
          endcase
        end else if (w == 16'hBFF8) begin
          m_shadow = m_time[63:32];
        end
      end
      m_time = t;
    end
  endtask

  // One clock: update model at the edge, compare outputs at the falling edge.
  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_eq("ready", mem_ready, m_busy);
    if (m_busy && m_rdv) check_eq("rdata", mem_rdata, m_rd);
    check_eq("irq3", IRQ3, m_msip);
    check_eq("irq7", IRQ7, (m_time >= m_cmp));
  endtask

  task automatic bus(input logic [15:0] a, input logic [3:0] s, input logic [31:0] d,
                     output logic [31:0] rd);
    int n;
    sel = 1'b1; mem_valid = 1'b1; mem_addr = a; mem_wstrb = s; mem_wdata = d;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!mem_ready && n < 8);
    check_eq("latency", n, 1);
    rd = mem_rdata;
    sel = 1'b0; mem_valid = 1'b0;
    $display("txn addr=%h wstrb=%h wdata=%h rdata=%h", a, s, d, rd);
    cycle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    int cnt, first, second, n;
    logic [15:0] addrs [6];
    addrs = '{16'h0000, 16'h4000, 16'h4004, 16'hBFF8, 16'hBFFC, 16'h0100};

    reset = 1'b1; sel = 1'b0; mem_valid = 1'b0;
    mem_addr = 16'h0; mem_wstrb = 4'h0; mem_wdata = 32'h0;
    cycle();
    cycle();
    check_eq("rst_ready", mem_ready, 1'b0);
    check_eq("rst_rdata", mem_rdata, 32'h0);
    check_eq("rst_irq7", IRQ7, 1'b0);
    check_eq("rst_irq3", IRQ3, 1'b0);
    reset = 1'b0;

    bus(16'h4004, 4'h0, 32'h0, r);
    check_eq("cmp_hi_rst", r, 32'hFFFF_FFFF);
    bus(16'hBFF8, 4'h0, 32'h0, r);
    check_eq("mtime_lo_early", (r < 32'd4), 1'b1);

    // Reset arriving together with a request: no response afterwards.
    sel = 1'b1; mem_valid = 1'b1; mem_addr = 16'h0; mem_wstrb = 4'hF; mem_wdata = 32'h1;
    reset = 1'b1;
    cycle();
    reset = 1'b0; sel = 1'b0; mem_valid = 1'b0;
    cycle();
    check_eq("midrst_ready", mem_ready, 1'b0);
    check_eq("midrst_msip", IRQ3, 1'b0);

    bus(16'h0000, 4'hF, 32'h1, r);
    check_eq("irq3_set", IRQ3, 1'b1);
    bus(16'h0000, 4'hF, 32'h0, r);
    check_eq("irq3_clr", IRQ3, 1'b0);

    // Request held three cycles: two accepts, responses two cycles apart.
    sel = 1'b1; mem_valid = 1'b1; mem_addr = 16'h0; mem_wstrb = 4'h0;
    cnt = 0; first = -1; second = -1;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin sel = 1'b0; mem_valid = 1'b0; end
      cycle();
      if (mem_ready) begin
        if (cnt == 0) first = i; else second = i;
        cnt++;
      end
    end
    check_eq("hold_count", cnt, 2);
    check_eq("hold_gap", second - first, 2);
    cycle();

    bus(16'h1234, 4'h0, 32'h0, r);
    check_eq("unmapped_rd", r, 32'h0);

    // Timer interrupt: compare 5, release mtime from 0.
    bus(16'hBFFC, 4'hF, 32'h0, r);
    bus(16'h4004, 4'hF, 32'h0, r);
    bus(16'h4000, 4'hF, 32'h5, r);
    bus(16'hBFF8, 4'hF, 32'h0, r);
    n = 0;
    while (!IRQ7 && n < 40) begin
      cycle();
      n++;
    end
    check_eq("irq7_rise_window", (n >= 14 && n <= 19), 1'b1);
    bus(16'h4000, 4'hF, 32'hFFFF_FFFF, r);
    check_eq("irq7_drop", IRQ7, 1'b0);

    // Carry from lo into hi.
    bus(16'hBFFC, 4'hF, 32'h0, r);
    bus(16'hBFF8, 4'hF, 32'hFFFF_FFFF, r);
    repeat (8) cycle();
    bus(16'hBFF8, 4'h0, 32'h0, r);
    bus(16'hBFFC, 4'h0, 32'h0, r);
    check_eq("mtime_carry", r, 32'h1);

    // Partial write to one byte lane.
    bus(16'hBFF8, 4'hF, 32'h0, r);
    bus(16'hBFF8, 4'h2, 32'h0000_AB00, r);
    bus(16'hBFF8, 4'h0, 32'h0, r);
    check_eq("lane_merge", r & 32'hFFFF_FF00, 32'h0000_AB00);

    // Tear-free read across a lo wrap.
    bus(16'hBFFC, 4'hF, 32'h0, r);
    bus(16'hBFF8, 4'hF, 32'hFFFF_FFF0, r);
    bus(16'hBFF8, 4'h0, 32'h0, r);
    repeat (80) cycle();
    bus(16'hBFFC, 4'h0, 32'h0, r);
`ifdef CLINT_MTIME_SNAPSHOT_EN
    check_eq("snapshot_hi", r, 32'h0);
`else
    check_eq("snapshot_hi", r, 32'h1);
`endif

    // Random traffic, checked cycle by cycle against the model.
    for (int k = 0; k < 150; k++) begin
      logic [15:0] a;
      logic [3:0]  s;
      a = addrs[$urandom_range(0, 5)];
      if ($urandom_range(0, 7) == 0) a = 16'($urandom);
      s = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      if ($urandom_range(0, 5) == 0) begin
        sel = 1'b0; mem_valid = 1'b1; mem_addr = a; mem_wstrb = s;
        cycle();
        mem_valid = 1'b0;
      end
      bus(a, s, $urandom, r);
      repeat ($urandom_range(0, 2)) cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
